// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit_pkg
// Purpose  : Shared types for the branch resolve unit: 2-bit counter states,
//            FSM encoding and the saturating-counter next-state function.
// Revision : 1.0 - initial release
// ============================================================================
package branch_resolve_unit_pkg;

    // 2-bit direction counter encodings
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic [0:0] {
        FSM_RUN   = 1'b0,
        FSM_FLUSH = 1'b1
    } fsm_state_t;

    // Counter update. A taken outcome from WNT jumps straight to ST.
    function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            case (cur)
                SNT:     nxt = WNT;
                default: nxt = ST;
            endcase
        end else begin
            case (cur)
                ST:      nxt = WT;
                default: nxt = SNT;
            endcase
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit_if
// Purpose  : Push (IF side), resolve (EX side) and update/redirect bundle of
//            the branch resolve unit. master = environment, slave = unit.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 5,
    parameter int OCC_W = 3
);
    logic             push_valid;
    logic             push_ready;
    logic [XLEN-1:0]  push_pc;
    logic [1:0]       push_state;
    logic             push_pred;
    logic [XLEN-1:0]  push_target;

    logic             res_valid;
    logic             res_taken;
    logic [XLEN-1:0]  res_target;

    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_index;
    logic [XLEN-1:0]  upd_target;
    logic [1:0]       upd_state;
    logic             upd_pred;
    logic [OCC_W-1:0] occupancy;
    logic             err_underflow;

    modport master (
        output push_valid, push_pc, push_state, push_pred, push_target,
        output res_valid, res_taken, res_target,
        input  push_ready, redirect_valid, redirect_pc,
        input  upd_valid, upd_index, upd_target, upd_state, upd_pred,
        input  occupancy, err_underflow
    );

    modport slave (
        input  push_valid, push_pc, push_state, push_pred, push_target,
        input  res_valid, res_taken, res_target,
        output push_ready, redirect_valid, redirect_pc,
        output upd_valid, upd_index, upd_target, upd_state, upd_pred,
        output occupancy, err_underflow
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bp_inflight_fifo
// Purpose  : In-order queue of predicted branches awaiting resolution, with a
//            synchronous clear that empties it and rewinds both pointers.
// Revision : 1.0 - initial release
// ============================================================================
module bp_inflight_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 67,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic             clear,
    input  wire logic [WIDTH-1:0] wr_data,
    output logic      [WIDTH-1:0] rd_data,
    output logic      [OCC_W-1:0] occupancy,
    output logic                  empty,
    output logic                  full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_occ;

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_tail] <= wr_data;
        end
    end

    // Pointers and occupancy; clear wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else if (clear) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (push) r_tail <= PTR_W'(r_tail + 1'b1);
            if (pop)  r_head <= PTR_W'(r_head + 1'b1);
            case ({push, pop})
                2'b10:   r_occ <= OCC_W'(r_occ + 1'b1);
                2'b01:   r_occ <= OCC_W'(r_occ - 1'b1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign rd_data   = r_mem[r_head];
    assign occupancy = r_occ;
    assign empty     = (r_occ == '0);
    assign full      = (r_occ == OCC_W'(DEPTH));
endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Resolves the oldest in-flight predicted branch: detects
//            mispredicts, redirects fetch, flushes wrong-path entries and
//            emits the BTB update record one cycle after resolution.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5,
    parameter int XLEN  = 32
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    branch_resolve_unit_if.slave bus
);
    localparam int OCC_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = 2 * XLEN + 3;

    fsm_state_t       r_state;
    fsm_state_t       w_state_nxt;
    logic [ENTRY_W-1:0] w_head;
    logic [XLEN-1:0]  w_head_pc;
    logic [1:0]       w_head_state;
    logic             w_head_pred;
    logic [XLEN-1:0]  w_head_target;
    logic [OCC_W-1:0] w_occ;
    logic             w_empty;
    logic             w_full;
    logic             w_push_ready;
    logic             w_res_fire;
    logic             w_mispred;
    logic             w_push_fire;
    logic             w_underflow;

    assign {w_head_pc, w_head_state, w_head_pred, w_head_target} = w_head;

    bp_inflight_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .OCC_W (OCC_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push_fire),
        .pop       (w_res_fire),
        .clear     (w_mispred),
        .wr_data   ({bus.push_pc, bus.push_state, bus.push_pred, bus.push_target}),
        .rd_data   (w_head),
        .occupancy (w_occ),
        .empty     (w_empty),
        .full      (w_full)
    );

    // Resolve/push qualification and FSM next state.
    always_comb begin
        w_state_nxt  = r_state;
        w_push_ready = (r_state == FSM_RUN) && !w_full;
        w_res_fire   = bus.res_valid && (r_state == FSM_RUN) && !w_empty;
        w_underflow  = bus.res_valid && (r_state == FSM_RUN) && w_empty;
        w_mispred    = w_res_fire &&
                       ((bus.res_taken != w_head_pred) ||
                        (bus.res_taken && (bus.res_target != w_head_target)));
        // A push arriving with a mispredict is wrong-path and is dropped.
        w_push_fire  = bus.push_valid && w_push_ready && !w_mispred;
        case (r_state)
            FSM_RUN:   if (w_mispred) w_state_nxt = FSM_FLUSH;
            FSM_FLUSH: w_state_nxt = FSM_RUN;
            default:   w_state_nxt = FSM_RUN;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FSM_RUN;
        else        r_state <= w_state_nxt;
    end

    // Registered update/redirect record and sticky underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.upd_valid      <= 1'b0;
            bus.upd_index      <= '0;
            bus.upd_target     <= '0;
            bus.upd_state      <= SNT;
            bus.upd_pred       <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
            bus.err_underflow  <= 1'b0;
        end else begin
            bus.upd_valid      <= w_res_fire;
            bus.redirect_valid <= w_mispred;
            if (w_underflow) bus.err_underflow <= 1'b1;
            if (w_res_fire) begin
                bus.upd_index  <= w_head_pc[IDX_W+1:2];
                bus.upd_target <= bus.res_taken ? bus.res_target : w_head_target;
                bus.upd_state  <= ctr_next(w_head_state, bus.res_taken);
                bus.upd_pred   <= ctr_next(w_head_state, bus.res_taken) >= WT;
            end
            if (w_mispred) begin
                bus.redirect_pc <= bus.res_taken ? bus.res_target
                                                 : XLEN'(w_head_pc + XLEN'(4));
            end
        end
    end

    assign bus.push_ready = w_push_ready;
    assign bus.occupancy  = w_occ;
endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Self-checking bench: directed cases plus random push/resolve
//            traffic compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;
    localparam int IDX_W = 5;
    localparam int XLEN  = 32;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  st;
        logic        pd;
        logic [31:0] tg;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model state
    ent_t q[$];
    bit   m_flush = 0;
    bit   m_err = 0;

    branch_resolve_unit_if #(.XLEN(XLEN), .IDX_W(IDX_W), .OCC_W(3)) bus ();

    branch_resolve_unit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Counter behaviour written as the transition table.
    function automatic logic [1:0] ref_ctr(input logic [1:0] s, input logic taken);
        logic [1:0] tk [4];
        logic [1:0] nt [4];
        tk = '{2'd1, 2'd3, 2'd3, 2'd3};
        nt = '{2'd0, 2'd0, 2'd0, 2'd2};
        return taken ? tk[s] : nt[s];
    endfunction

    task automatic drive(input bit pv, input logic [31:0] pc, input logic [1:0] st, input bit pd,
                         input logic [31:0] tg, input bit rv, input bit rt, input logic [31:0] rtg);
        bus.push_valid  = pv;
        bus.push_pc     = pc;
        bus.push_state  = st;
        bus.push_pred   = pd;
        bus.push_target = tg;
        bus.res_valid   = rv;
        bus.res_taken   = rt;
        bus.res_target  = rtg;
    endtask

    // One clock: predict from the model, advance the edge, compare outputs.
    task automatic step();
        bit          e_rdy, e_upd, mis;
        ent_t        h;
        ent_t        n;
        logic [31:0] e_tgt, e_rpc;
        logic [1:0]  e_st;
        logic [4:0]  e_idx;
        e_upd = 0; mis = 0; e_tgt = 0; e_rpc = 0; e_st = 0; e_idx = 0;
        e_rdy = !m_flush && (q.size() < DEPTH);
        check("push_ready", {63'd0, bus.push_ready}, {63'd0, e_rdy});
        if (bus.res_valid && !m_flush) begin
            if (q.size() == 0) begin
                m_err = 1;
            end else begin
                h     = q.pop_front();
                mis   = (bus.res_taken != h.pd) || (bus.res_taken && bus.res_target != h.tg);
                e_upd = 1;
                e_idx = 5'((h.pc / 4) % 32);
                e_tgt = bus.res_taken ? bus.res_target : h.tg;
                e_st  = ref_ctr(h.st, bus.res_taken);
                e_rpc = bus.res_taken ? bus.res_target : h.pc + 32'd4;
            end
        end
        if (bus.push_valid && e_rdy && !mis) begin
            n = '{bus.push_pc, bus.push_state, bus.push_pred, bus.push_target};
            q.push_back(n);
        end
        if (mis) q.delete();
        m_flush = mis;
        @(posedge clk);
        #1;
        check("upd_valid", {63'd0, bus.upd_valid}, {63'd0, e_upd});
        check("redirect_valid", {63'd0, bus.redirect_valid}, {63'd0, mis});
        if (e_upd) begin
            check("upd_index", {59'd0, bus.upd_index}, {59'd0, e_idx});
            check("upd_target", {32'd0, bus.upd_target}, {32'd0, e_tgt});
            check("upd_state", {62'd0, bus.upd_state}, {62'd0, e_st});
            check("upd_pred", {63'd0, bus.upd_pred}, {63'd0, e_st[1]});
        end
        if (mis) check("redirect_pc", {32'd0, bus.redirect_pc}, {32'd0, e_rpc});
        check("occupancy", {61'd0, bus.occupancy}, 64'(q.size()));
        check("err_underflow", {63'd0, bus.err_underflow}, {63'd0, m_err});
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        logic [31:0] pc, tg, rtg;
        logic [1:0]  st;
        bit          pd, rt;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_upd_valid", {63'd0, bus.upd_valid}, 64'd0);
        check("rst_occupancy", {61'd0, bus.occupancy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mispredict: not-taken prediction, actually taken
        drive(1, 32'h100, 2'b00, 0, 32'h0, 0, 0, 0);           step();
        drive(0, 0, 0, 0, 0, 1, 1, 32'h200);                   step();
        check("dir_redirect_pc", {32'd0, bus.redirect_pc}, 64'h200);
        drive(1, 32'h300, 2'b00, 0, 32'h0, 1, 0, 0);           step();  // FLUSH: all ignored
        // Correct taken prediction
        drive(1, 32'h40, 2'b11, 1, 32'h80, 0, 0, 0);           step();
        drive(0, 0, 0, 0, 0, 1, 1, 32'h80);                    step();
        check("dir_state_st", {62'd0, bus.upd_state}, 64'd3);
        // Predicted taken, actually not taken
        drive(1, 32'h44, 2'b11, 1, 32'h90, 0, 0, 0);           step();
        drive(0, 0, 0, 0, 0, 1, 0, 0);                         step();
        check("dir_redirect_nt", {32'd0, bus.redirect_pc}, 64'h48);
        check("dir_index_nt", {59'd0, bus.upd_index}, 64'h11);
        idle();

        // Fill, then push+resolve while full, then stream through the wrap
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h1000 + 32'(i * 4), 2'b11, 1, 32'h2000 + 32'(i * 16), 0, 0, 0);
            step();
        end
        drive(1, 32'h1100, 2'b11, 1, 32'h2100, 1, 1, q[0].tg); step();
        check("full_push_rej", {61'd0, bus.occupancy}, 64'd3);
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h1200 + 32'(i * 4), 2'b10, 1, 32'h3000 + 32'(i * 8), 1, 1, q[0].tg);
            step();
        end
        while (q.size() > 0) begin
            drive(0, 0, 0, 0, 0, 1, 1, q[0].tg);
            step();
        end

        // Resolve on empty queue
        drive(0, 0, 0, 0, 0, 1, 1, 32'h4);                     step();
        idle();
        check("err_sticky", {63'd0, bus.err_underflow}, 64'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            pc  = $urandom & 32'hffff_fffc;
            tg  = $urandom & 32'hffff_fffc;
            st  = 2'($urandom_range(0, 3));
            pd  = ($urandom_range(0, 7) == 0) ? ~st[1] : st[1];
            rt  = 1'($urandom_range(0, 1));
            rtg = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[0].tg : ($urandom & 32'hffff_fffc);
            drive(1'($urandom_range(0, 1)), pc, st, pd, tg, ($urandom_range(0, 2) != 0), rt, rtg);
            step();
        end

        // Asynchronous reset mid-stream, with the queue populated
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h5000 + 32'(i * 4), 2'b11, 1, 32'h6000, 0, 0, 0);
            step();
        end
        drive(1, 32'h7000, 2'b11, 1, 32'h6000, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_occupancy", {61'd0, bus.occupancy}, 64'd0);
        check("async_upd_valid", {63'd0, bus.upd_valid}, 64'd0);
        check("async_redirect", {63'd0, bus.redirect_valid}, 64'd0);
        check("async_err", {63'd0, bus.err_underflow}, 64'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        m_flush = 0;
        m_err = 0;
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
